// File: rtl/gen_step_ctrl_pkg.sv
// Shared widths, FSM state encoding and the Life rule for the generation-step controller.
package gen_step_ctrl_pkg;

  localparam int ADDR_WIDTH  = 8;
  localparam int GEN_STATE_W = 3;
  localparam int NBR_LAST    = 8;

  typedef enum logic [GEN_STATE_W-1:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } gen_state_e;

  function automatic logic life_rule(input logic alive, input logic [3:0] n);
    return (n == 4'd3) || (alive && (n == 4'd2));
  endfunction

endpackage

// File: rtl/gen_step_ctrl_neighbor_addr_gen.sv
// Maps (cell, neighbourhood index 0..8) to a board address plus an in-board flag.
// GEN_STEP_WRAP_EN selects toroidal wrap; otherwise off-board neighbours are flagged out of range.
module neighbor_addr_gen
  import gen_step_ctrl_pkg::*;
#(
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8
) (
  input  logic [ADDR_WIDTH-1:0] row_i,
  input  logic [ADDR_WIDTH-1:0] col_i,
  input  logic [3:0]            idx_i,
  output logic [ADDR_WIDTH-1:0] addr_r_o,
  output logic [ADDR_WIDTH-1:0] addr_c_o,
  output logic                  in_range_o
);

  logic [1:0]          dy, dx;
  logic [ADDR_WIDTH:0] r_res, c_res;

  // Offset code 0 = -1, 1 = 0, 2 = +1; result is {in_range, address}.
  function automatic logic [ADDR_WIDTH:0] shift_axis(input logic [ADDR_WIDTH-1:0] pos,
                                                     input logic [1:0] d,
                                                     input logic [ADDR_WIDTH-1:0] last);
    logic [ADDR_WIDTH:0] res;
    res = {1'b1, pos};
    if (d == 2'd0) begin
      if (pos == {ADDR_WIDTH{1'b0}})
`ifdef GEN_STEP_WRAP_EN
        res = {1'b1, last};
`else
        res = {1'b0, pos - 1'b1};
`endif
      else
        res = {1'b1, pos - 1'b1};
    end else if (d == 2'd2) begin
      if (pos == last)
`ifdef GEN_STEP_WRAP_EN
        res = {1'b1, {ADDR_WIDTH{1'b0}}};
`else
        res = {1'b0, pos + 1'b1};
`endif
      else
        res = {1'b1, pos + 1'b1};
    end
    return res;
  endfunction

  always_comb begin
    if (idx_i < 4'd3) begin
      dy = 2'd0;
      dx = idx_i[1:0];
    end else if (idx_i < 4'd6) begin
      dy = 2'd1;
      dx = 2'(idx_i - 4'd3);
    end else begin
      dy = 2'd2;
      dx = 2'(idx_i - 4'd6);
    end
  end

  assign r_res      = shift_axis(row_i, dy, ADDR_WIDTH'(MAP_HEIGHT - 1));
  assign c_res      = shift_axis(col_i, dx, ADDR_WIDTH'(MAP_WIDTH - 1));
  assign addr_r_o   = r_res[ADDR_WIDTH-1:0];
  assign addr_c_o   = c_res[ADDR_WIDTH-1:0];
  assign in_range_o = r_res[ADDR_WIDTH] & c_res[ADDR_WIDTH];

endmodule

// File: rtl/gen_step_ctrl.sv
// One Game-of-Life generation per step_req rising edge: 9 neighbourhood reads, drain, one write per cell.
// Board edges wrap when GEN_STEP_WRAP_EN is defined, otherwise off-board cells count as dead.
module gen_step_ctrl
  import gen_step_ctrl_pkg::*;
#(
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_req,
  output logic [ADDR_WIDTH-1:0] rAddrR,
  output logic [ADDR_WIDTH-1:0] rAddrC,
  input  logic                  read_data,
  output logic [ADDR_WIDTH-1:0] wAddrR,
  output logic [ADDR_WIDTH-1:0] wAddrC,
  output logic                  write_en,
  output logic                  write_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           gen_count
);

  gen_state_e            state_q;
  logic                  step_q;
  logic [ADDR_WIDTH-1:0] cell_r_q, cell_c_q;
  logic [3:0]            idx_q;
  logic [ADDR_WIDTH-1:0] rar_q, rac_q, war_q, wac_q;
  logic                  in_q;
  logic                  tag_vld_q, tag_ctr_q, tag_in_q;
  logic [3:0]            n_q, n_d;
  logic                  alive_q, alive_d;
  logic                  we_q, wd_q, busy_q, done_q;
  logic [15:0]           gcnt_q;

  logic                  step_edge, last_col, last_cell;
  logic [ADDR_WIDTH-1:0] iss_r, iss_c, ag_r, ag_c;
  logic [3:0]            iss_idx;
  logic                  ag_in;

  assign step_edge = step_req & ~step_q;
  assign last_col  = (cell_c_q == ADDR_WIDTH'(MAP_WIDTH - 1));
  assign last_cell = last_col && (cell_r_q == ADDR_WIDTH'(MAP_HEIGHT - 1));

  // Address of the read that will be visible on rAddr in the following cycle.
  always_comb begin
    iss_r   = cell_r_q;
    iss_c   = cell_c_q;
    iss_idx = idx_q + 4'd1;
    case (state_q)
      IDLE: begin
        iss_r   = '0;
        iss_c   = '0;
        iss_idx = '0;
      end
      WRITE: begin
        iss_idx = '0;
        if (last_col) begin
          iss_c = '0;
          iss_r = cell_r_q + 1'b1;
        end else begin
          iss_c = cell_c_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  neighbor_addr_gen #(
    .MAP_WIDTH (MAP_WIDTH),
    .MAP_HEIGHT(MAP_HEIGHT)
  ) u_naddr (
    .row_i     (iss_r),
    .col_i     (iss_c),
    .idx_i     (iss_idx),
    .addr_r_o  (ag_r),
    .addr_c_o  (ag_c),
    .in_range_o(ag_in)
  );

  // read_data belongs to the address issued one cycle earlier, tracked by the tag_* registers.
  always_comb begin
    n_d     = n_q;
    alive_d = alive_q;
    if (tag_vld_q) begin
      if (tag_ctr_q)
        alive_d = tag_in_q & read_data;
      else
        n_d = n_q + {3'b000, tag_in_q & read_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      step_q    <= 1'b0;
      cell_r_q  <= '0;
      cell_c_q  <= '0;
      idx_q     <= '0;
      rar_q     <= '0;
      rac_q     <= '0;
      in_q      <= 1'b0;
      war_q     <= '0;
      wac_q     <= '0;
      tag_vld_q <= 1'b0;
      tag_ctr_q <= 1'b0;
      tag_in_q  <= 1'b0;
      n_q       <= '0;
      alive_q   <= 1'b0;
      we_q      <= 1'b0;
      wd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gcnt_q    <= '0;
    end else begin
      step_q    <= step_req;
      tag_vld_q <= (state_q == READ);
      tag_ctr_q <= (idx_q == 4'd4);
      tag_in_q  <= in_q;
      n_q       <= n_d;
      alive_q   <= alive_d;
      case (state_q)
        IDLE: begin
          if (step_edge) begin
            state_q  <= READ;
            busy_q   <= 1'b1;
            cell_r_q <= iss_r;
            cell_c_q <= iss_c;
            idx_q    <= iss_idx;
            rar_q    <= ag_r;
            rac_q    <= ag_c;
            in_q     <= ag_in;
          end
        end
        READ: begin
          if (idx_q == 4'(NBR_LAST)) begin
            state_q <= DRAIN;
          end else begin
            idx_q <= iss_idx;
            rar_q <= ag_r;
            rac_q <= ag_c;
            in_q  <= ag_in;
          end
        end
        DRAIN: begin
          state_q <= WRITE;
          we_q    <= 1'b1;
          wd_q    <= life_rule(alive_d, n_d);
          war_q   <= cell_r_q;
          wac_q   <= cell_c_q;
        end
        WRITE: begin
          we_q    <= 1'b0;
          n_q     <= '0;
          alive_q <= 1'b0;
          if (last_cell) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            gcnt_q  <= gcnt_q + 16'd1;
          end else begin
            state_q  <= READ;
            cell_r_q <= iss_r;
            cell_c_q <= iss_c;
            idx_q    <= iss_idx;
            rar_q    <= ag_r;
            rac_q    <= ag_c;
            in_q     <= ag_in;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rAddrR     = rar_q;
  assign rAddrC     = rac_q;
  assign wAddrR     = war_q;
  assign wAddrC     = wac_q;
  assign write_en   = we_q;
  assign write_data = wd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign gen_count  = gcnt_q;

endmodule

// File: tb/tb_gen_step_ctrl.sv
// Directed bench for gen_step_ctrl on an 8x8 board; edge expectations follow GEN_STEP_WRAP_EN.
module tb_gen_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_req = 1'b0;
  logic        read_data = 1'b0;
  logic [7:0]  rAddrR, rAddrC, wAddrR, wAddrC;
  logic        write_en, write_data, busy, done;
  logic [15:0] gen_count;

  logic [63:0] cur = '0;
  logic [63:0] nxt;
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  gen_step_ctrl #(.MAP_WIDTH(8), .MAP_HEIGHT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .step_req  (step_req),
    .rAddrR    (rAddrR),
    .rAddrC    (rAddrC),
    .read_data (read_data),
    .wAddrR    (wAddrR),
    .wAddrC    (wAddrC),
    .write_en  (write_en),
    .write_data(write_data),
    .busy      (busy),
    .done      (done),
    .gen_count (gen_count)
  );

  // Board memories: one-cycle read latency; off-board reads return 1 so they must be ignored.
  always @(posedge clk) begin
    if (rAddrR < 8'd8 && rAddrC < 8'd8) read_data <= cur[{rAddrR[2:0], rAddrC[2:0]}];
    else read_data <= 1'b1;
    if (write_en) begin
      nxt[{wAddrR[2:0], wAddrC[2:0]}] <= write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [63:0] cb(input int r, input int c);
    return 64'd1 << (r * 8 + c);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    step_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_step();
    @(posedge clk);
    #1 step_req = 1'b1;
    @(posedge clk);
    #1 step_req = 1'b0;
  endtask

  task automatic run_gen(output int cyc, output bit to);
    cyc = 0;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({busy, done, write_en, write_data} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000", {busy, done, write_en, write_data});
    end
    total++;
    if (gen_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_gen_count got=%0d want=0", gen_count);
    end
    total++;
    if ({rAddrR, rAddrC, wAddrR, wAddrC} !== 32'd0) begin
      bad++;
      $display("FAIL reset_addr got=%h want=0", {rAddrR, rAddrC, wAddrR, wAddrC});
    end
    rst = 1'b1;
  endtask

  task automatic test_blinker();
    int cyc, w0, d0;
    bit to;
    logic [63:0] exp;
    do_reset();
    cur = cb(3, 2) | cb(3, 3) | cb(3, 4);
    exp = cb(2, 3) | cb(3, 3) | cb(4, 3);
    w0 = wr_cnt;
    d0 = done_cnt;
    start_step();
    run_gen(cyc, to);
    total++;
    if (to) begin bad++; $display("FAIL blinker_timeout got=no_done want=done"); end
    total++;
    if (cyc !== 705) begin bad++; $display("FAIL blinker_cycles got=%0d want=705", cyc); end
    total++;
    if (gen_count !== 16'd1) begin bad++; $display("FAIL blinker_gen_count got=%0d want=1", gen_count); end
    @(negedge clk);
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL blinker_after got=%b want=00", {done, busy}); end
    total++;
    if (wr_cnt - w0 !== 64) begin bad++; $display("FAIL blinker_writes got=%0d want=64", wr_cnt - w0); end
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL blinker_done_pulses got=%0d want=1", done_cnt - d0); end
    total++;
    if (nxt !== exp) begin bad++; $display("FAIL blinker_board got=%h want=%h", nxt, exp); end
  endtask

  task automatic test_block();
    int cyc;
    bit to;
    logic [63:0] exp;
    do_reset();
    exp = cb(1, 1) | cb(1, 2) | cb(2, 1) | cb(2, 2);
    cur = exp;
    for (int g = 0; g < 3; g++) begin
      start_step();
      run_gen(cyc, to);
      total++;
      if (to) begin bad++; $display("FAIL block_timeout gen=%0d got=no_done want=done", g); end
      total++;
      if (nxt !== exp) begin bad++; $display("FAIL block_board gen=%0d got=%h want=%h", g, nxt, exp); end
      cur = nxt;
      @(negedge clk);
    end
    total++;
    if (gen_count !== 16'd3) begin bad++; $display("FAIL block_gen_count got=%0d want=3", gen_count); end
  endtask

  task automatic test_edge();
    int cyc;
    bit to;
    logic [63:0] exp;
    do_reset();
    cur = cb(0, 7) | cb(1, 7) | cb(2, 7);
`ifdef GEN_STEP_WRAP_EN
    exp = cb(1, 6) | cb(1, 7) | cb(1, 0);
`else
    exp = cb(1, 6) | cb(1, 7);
`endif
    start_step();
    run_gen(cyc, to);
    total++;
    if (to) begin bad++; $display("FAIL edge_timeout got=no_done want=done"); end
    total++;
    if (nxt !== exp) begin bad++; $display("FAIL edge_board got=%h want=%h", nxt, exp); end
    @(negedge clk);
  endtask

  task automatic test_held();
    int d0;
    do_reset();
    cur = cb(3, 2) | cb(3, 3) | cb(3, 4);
    d0 = done_cnt;
    @(posedge clk);
    #1 step_req = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (i == 90) step_req = 1'b0;
      if (i == 100) begin
        step_req = 1'b1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL held_busy_at_edge got=%b want=1", busy); end
      end
    end
    step_req = 1'b0;
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL held_done_pulses got=%0d want=1", done_cnt - d0); end
    total++;
    if (gen_count !== 16'd1) begin bad++; $display("FAIL held_gen_count got=%0d want=1", gen_count); end
  endtask

  task automatic test_reset_mid();
    int cyc, w0, d0;
    bit to;
    do_reset();
    cur = cb(3, 2) | cb(3, 3) | cb(3, 4);
    start_step();
    run_gen(cyc, to);
    @(negedge clk);
    start_step();
    repeat (300) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({write_en, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL midrst_ctrl got=%b want=000", {write_en, busy, done});
    end
    total++;
    if (gen_count !== 16'd0) begin bad++; $display("FAIL midrst_gen_count got=%0d want=0", gen_count); end
    w0 = wr_cnt;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (800) @(negedge clk);
    total++;
    if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL midrst_writes got=%0d want=0", wr_cnt - w0); end
    total++;
    if (done_cnt - d0 !== 0) begin bad++; $display("FAIL midrst_done got=%0d want=0", done_cnt - d0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_after got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_block();
    test_edge();
    test_held();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
